// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential matrix multiplier: FSM encoding and
// the in-memory matrix layout (two header words followed by row-major data).
package matmul_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_H0, S_H1, S_H2, S_H3, S_H4, S_CHK,
        S_WH0, S_WH1, S_ELEM, S_RA, S_RB, S_MC, S_WR, S_DONE
    } state_t;

    localparam int unsigned HDR_ROWS_OFF = 0;
    localparam int unsigned HDR_COLS_OFF = 4;
    localparam int unsigned DATA_OFF     = 8;
    localparam int unsigned WORD_BYTES   = 4;

endpackage

// File: rtl/matmul_seq_if.sv
// Single-port word memory bus used by the multiplier; read data returns
// one cycle after the read strobe.
interface matmul_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, mem_rd, mem_we, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_rd, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/matmul_mac.sv
// Multiply-accumulate register with clear, load and accumulate controls.
// acc_next exposes the value the register takes on the coming edge.
module matmul_mac #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] load_val,
    input  logic [DATA_W-1:0] a_val,
    input  logic [DATA_W-1:0] b_val,
    output logic [DATA_W-1:0] acc_next
);
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] prod;

    always_comb begin
        // Low DATA_W bits of the product are the same for signed and unsigned operands.
        prod  = a_val * b_val;
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (load)
            acc_d = load_val;
        else if (acc_en)
            acc_d = acc_q + prod;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_next = acc_d;
endmodule

// File: rtl/matmul_seq.sv
// Sequential C = A*B (or C += A*B) engine over a single word memory,
// one multiply-accumulate per three cycles with all bus outputs registered.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              acc_mode,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    matmul_seq_if.master      mem,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [DIM_W-1:0] MAX_DIM = '1;

    state_t state_q, state_d;
    logic acc_mode_q, acc_mode_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [DATA_W-1:0] arows_q, arows_d, acols_q, acols_d, brows_q, brows_d, bcols_q, bcols_d;
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_W-1:0] a_val_q, a_val_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic mem_rd_q, mem_rd_d, mem_we_q, mem_we_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [DIM_W-1:0]  m_dim, n_dim, k_dim;
    logic              mac_clr, mac_load, mac_acc;
    logic [DATA_W-1:0] mac_acc_next;

    assign m_dim = arows_q[DIM_W-1:0];
    assign k_dim = acols_q[DIM_W-1:0];
    assign n_dim = bcols_q[DIM_W-1:0];

    function automatic logic dim_bad(input logic [DATA_W-1:0] d);
        return (d == '0) || (d > DATA_W'(MAX_DIM));
    endfunction

    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [DIM_W-1:0] row,
                                                    input logic [DIM_W-1:0] col,
                                                    input logic [DIM_W-1:0] ncols);
        return base + ADDR_W'(DATA_OFF)
             + ADDR_W'(WORD_BYTES) * (ADDR_W'(row) * ADDR_W'(ncols) + ADDR_W'(col));
    endfunction

    // The C read issued in ELEM arrives during the first RA of the element.
    assign mac_clr  = (state_q == S_ELEM) && !acc_mode_q;
    assign mac_load = (state_q == S_RA) && acc_mode_q && (k_q == '0);
    assign mac_acc  = (state_q == S_MC);

    matmul_mac #(.DATA_W(DATA_W)) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr      (mac_clr),
        .load     (mac_load),
        .acc_en   (mac_acc),
        .load_val (mem.mem_rdata),
        .a_val    (a_val_q),
        .b_val    (mem.mem_rdata),
        .acc_next (mac_acc_next)
    );

    always_comb begin
        state_d     = state_q;
        acc_mode_d  = acc_mode_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_c_d    = addr_c_q;
        arows_d     = arows_q;
        acols_d     = acols_q;
        brows_d     = brows_q;
        bcols_d     = bcols_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        a_val_d     = a_val_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_we_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        // Outputs are computed for the state being entered, so every strobe is a flop.
        case (state_q)
            S_IDLE: if (start) begin
                acc_mode_d = acc_mode;
                addr_a_d   = addr_a;
                addr_b_d   = addr_b;
                addr_c_d   = addr_c;
                err_d      = 1'b0;
                state_d    = S_H0;
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_a + ADDR_W'(HDR_ROWS_OFF);
            end
            S_H0: begin
                state_d    = S_H1;
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_a_q + ADDR_W'(HDR_COLS_OFF);
            end
            S_H1: begin
                arows_d    = mem.mem_rdata;
                state_d    = S_H2;
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_b_q + ADDR_W'(HDR_ROWS_OFF);
            end
            S_H2: begin
                acols_d    = mem.mem_rdata;
                state_d    = S_H3;
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_b_q + ADDR_W'(HDR_COLS_OFF);
            end
            S_H3: begin
                brows_d = mem.mem_rdata;
                state_d = S_H4;
            end
            S_H4: begin
                bcols_d = mem.mem_rdata;
                state_d = S_CHK;
            end
            S_CHK: begin
                i_d = '0;
                j_d = '0;
                k_d = '0;
                if (acols_q != brows_q || dim_bad(arows_q) || dim_bad(acols_q) || dim_bad(bcols_q)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d     = S_WH0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_c_q + ADDR_W'(HDR_ROWS_OFF);
                    mem_wdata_d = arows_q;
                end
            end
            S_WH0: begin
                state_d     = S_WH1;
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_c_q + ADDR_W'(HDR_COLS_OFF);
                mem_wdata_d = bcols_q;
            end
            S_WH1: begin
                state_d    = S_ELEM;
                mem_rd_d   = acc_mode_q;
                mem_addr_d = elem_addr(addr_c_q, i_q, j_q, n_dim);
            end
            S_ELEM: begin
                state_d    = S_RA;
                mem_rd_d   = 1'b1;
                mem_addr_d = elem_addr(addr_a_q, i_q, '0, k_dim);
            end
            S_RA: begin
                state_d    = S_RB;
                mem_rd_d   = 1'b1;
                mem_addr_d = elem_addr(addr_b_q, k_q, j_q, n_dim);
            end
            S_RB: begin
                a_val_d = mem.mem_rdata;
                state_d = S_MC;
            end
            S_MC: begin
                if (k_q == k_dim - 1'b1) begin
                    state_d     = S_WR;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = elem_addr(addr_c_q, i_q, j_q, n_dim);
                    mem_wdata_d = mac_acc_next;
                end else begin
                    k_d        = k_q + 1'b1;
                    state_d    = S_RA;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = elem_addr(addr_a_q, i_q, k_q + 1'b1, k_dim);
                end
            end
            S_WR: begin
                k_d = '0;
                if (j_q == n_dim - 1'b1 && i_q == m_dim - 1'b1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (j_q == n_dim - 1'b1) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    state_d    = S_ELEM;
                    mem_rd_d   = acc_mode_q;
                    mem_addr_d = elem_addr(addr_c_q, i_d, j_d, n_dim);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_mode_q  <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
            arows_q     <= '0;
            acols_q     <= '0;
            brows_q     <= '0;
            bcols_q     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_val_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_mode_q  <= acc_mode_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_c_q    <= addr_c_d;
            arows_q     <= arows_d;
            acols_q     <= acols_d;
            brows_q     <= brows_d;
            bcols_q     <= bcols_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            a_val_q     <= a_val_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_rd    = mem_rd_q;
    assign mem.mem_we    = mem_we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule
